// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised redirect, stall, and predecoded
// call/return prediction backed by a circular return address stack.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] PC_INIT   = 32'h0000_3000,
    parameter int unsigned      STEP      = 4,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter int unsigned      CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_target,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             pd_call,
    input  logic [WIDTH-1:0] pd_target,
    input  logic             pd_ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [CW-1:0]    ras_count,
    output logic             ras_hit,
    output logic             ras_miss
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d, ptr_dec;
    logic             hit_q, hit_d, miss_q, miss_d;
    logic             push;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    assign pc_inc  = pc_q + WIDTH'(STEP);
    assign ptr_dec = ptr_q - PW'(1);

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        hit_d  = 1'b0;
        miss_d = 1'b0;
        push   = 1'b0;
        if (exc_valid) begin
            pc_d  = exc_target;
            cnt_d = '0;
            ptr_d = '0;
        end else if (br_valid) begin
            pc_d = br_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pd_call) begin
            // When full, ptr already points at the oldest entry, so the push overwrites it.
            pc_d  = pd_target;
            push  = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (pd_ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[ptr_dec];
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CW'(1);
                hit_d = 1'b1;
            end else begin
                pc_d   = pc_inc;
                miss_d = 1'b1;
            end
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= PC_INIT;
            cnt_q  <= '0;
            ptr_q  <= '0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    // Entry contents are don't-care after reset; only count/ptr qualify them.
    always_ff @(posedge clk) begin
        if (push) ras_q[ptr_q] <= pc_inc;
    end

    assign pc_out    = pc_q;
    assign ras_count = cnt_q;
    assign ras_hit   = hit_q;
    assign ras_miss  = miss_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues hand-computed results per
// cycle, a monitor checks them just after each rising edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, exc_valid, br_valid, pd_call, pd_ret;
    logic [31:0] exc_target, br_target, pd_target;
    logic [31:0] pc_out;
    logic [2:0]  ras_count;
    logic        ras_hit, ras_miss;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        hit;
        logic        miss;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_step = 0;

    pc_unit #(
        .WIDTH    (32),
        .PC_INIT  (32'h0000_3000),
        .STEP     (4),
        .RAS_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .exc_valid (exc_valid),
        .exc_target(exc_target),
        .br_valid  (br_valid),
        .br_target (br_target),
        .pd_call   (pd_call),
        .pd_target (pd_target),
        .pd_ret    (pd_ret),
        .pc_out    (pc_out),
        .ras_count (ras_count),
        .ras_hit   (ras_hit),
        .ras_miss  (ras_miss)
    );

    always #5 clk = ~clk;

    // Called at a negedge: apply inputs for the next rising edge, queue the result.
    task automatic step(input logic s, input logic e, input logic [31:0] et,
                        input logic b, input logic [31:0] bt,
                        input logic c, input logic [31:0] ct, input logic r,
                        input logic [31:0] epc, input logic [2:0] ecnt,
                        input logic eh, input logic em);
        exp_t x;
        stall = s; exc_valid = e; exc_target = et; br_valid = b; br_target = bt;
        pd_call = c; pd_target = ct; pd_ret = r;
        n_step++;
        x.id = n_step; x.pc = epc; x.cnt = ecnt; x.hit = eh; x.miss = em;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] epc, input logic [2:0] ecnt, input logic em);
        step(0, 0, 0, 0, 0, 0, 0, 0, epc, ecnt, 0, em);
    endtask

    task automatic direct_check(input string name, input logic [31:0] epc);
        n_cmp++;
        if (pc_out !== epc || ras_count !== 3'd0 || ras_hit !== 1'b0 || ras_miss !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: pc=%h cnt=%0d hit=%b miss=%b, expected pc=%h cnt=0 hit=0 miss=0",
                     name, pc_out, ras_count, ras_hit, ras_miss, epc);
        end
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_cmp++;
                if (pc_out !== x.pc || ras_count !== x.cnt || ras_hit !== x.hit || ras_miss !== x.miss) begin
                    n_fail++;
                    $display("FAIL step%0d: pc=%h cnt=%0d hit=%b miss=%b, expected pc=%h cnt=%0d hit=%b miss=%b",
                             x.id, pc_out, ras_count, ras_hit, ras_miss, x.pc, x.cnt, x.hit, x.miss);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1;
        stall = 0; exc_valid = 0; br_valid = 0; pd_call = 0; pd_ret = 0;
        exc_target = '0; br_target = '0; pd_target = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        direct_check("reset", 32'h0000_3000);

        // free-running sequence
        idle(32'h3004, 0, 0);
        idle(32'h3008, 0, 0);
        idle(32'h300C, 0, 0);

        // asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1 direct_check("async_reset", 32'h0000_3000);
        @(negedge clk);
        rst = 1'b0;

        // stall, then branch while stalled
        idle(32'h3004, 0, 0);
        idle(32'h3008, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0);
        step(1, 0, 0, 1, 32'h4000, 0, 0, 0, 32'h4000, 0, 0, 0);

        // simple call / return
        step(0, 0, 0, 1, 32'h3010, 0, 0, 0, 32'h3010, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h5000, 0, 32'h5000, 1, 0, 0);
        idle(32'h5004, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h3014, 0, 1, 0);
        idle(32'h3018, 0, 0);

        // five nested calls overflow a 4-deep stack
        step(0, 0, 0, 1, 32'h3000, 0, 0, 0, 32'h3000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h3100, 0, 32'h3100, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h3200, 0, 32'h3200, 2, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h3300, 0, 32'h3300, 3, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h3400, 0, 32'h3400, 4, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h3500, 0, 32'h3500, 4, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h3404, 3, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h3304, 2, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h3204, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h3104, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h3108, 0, 0, 1);
        idle(32'h310C, 0, 0);

        // exception beats branch and call, flushes the stack
        step(0, 0, 0, 0, 0, 1, 32'h7000, 0, 32'h7000, 1, 0, 0);
        step(0, 1, 32'h8000_0180, 1, 32'h6000, 1, 32'h9999, 0, 32'h8000_0180, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0184, 0, 0, 1);
        // stall suppresses predecode
        step(1, 0, 0, 0, 0, 1, 32'h1234, 0, 32'h8000_0184, 0, 0, 0);

        // wrap-around and simultaneous call/return
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        idle(32'h0000_0000, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h9000, 1, 32'h9000, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0004, 0, 1, 0);

        // branch leaves the stack intact
        step(0, 0, 0, 0, 0, 1, 32'hA000, 0, 32'hA000, 1, 0, 0);
        step(0, 0, 0, 1, 32'h0100, 0, 0, 0, 32'h0100, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0008, 0, 1, 0);
        idle(32'h0000_000C, 0, 0);

        stall = 0; exc_valid = 0; br_valid = 0; pd_call = 0; pd_ret = 0;
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries unchecked, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised fetch-stage program counter for the dynamic pipeline CPU. It generalises the plain PC register with stall, prioritised redirect (exception, branch resolution), predecoded call/return handling and a circular return address stack (RAS) of configurable depth. It sits at the head of IF and drives the instruction memory address.

Parameters:
WIDTH, 32, PC width in bits
PC_INIT, 32'h0000_3000, PC value loaded on reset
STEP, 4, sequential increment in bytes
RAS_DEPTH, 4, return address stack entries; power of two, >= 2
CW, $clog2(RAS_DEPTH+1), width of ras_count (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold PC (hazard unit)
exc_valid  in  1  exception/eret redirect
exc_target  in  WIDTH  exception redirect address
br_valid  in  1  branch/jump resolved in EX, redirect required
br_target  in  WIDTH  resolved target
pd_call  in  1  instruction at pc_out predecodes as call
pd_target  in  WIDTH  call target from predecode
pd_ret  in  1  instruction at pc_out predecodes as return
pc_out  out  WIDTH  current fetch PC (registered)
ras_count  out  CW  valid RAS entries (registered)
ras_hit  out  1  registered 1-cycle pulse: last update took a return target from RAS
ras_miss  out  1  registered 1-cycle pulse: return seen with RAS empty

Behaviour:
- Reset (async, immediate): pc_out=PC_INIT, ras_count=0, RAS pointer=0, ras_hit=0, ras_miss=0. RAS entry contents are don't-care.
- All state updates on posedge clk. pc_out changes one cycle after the selecting inputs are sampled. No combinational path from inputs to outputs.
- Next-PC priority (highest first):
  1. exc_valid: pc<=exc_target; RAS flushed (count=0, ptr=0).
  2. br_valid: pc<=br_target; RAS unchanged.
  3. stall: pc held; RAS unchanged; pd_* ignored.
  4. pd_call: pc<=pd_target; push pc_out+STEP.
  5. pd_ret with count>0: pc<=top entry; pop; ras_hit=1.
  6. pd_ret with count==0: pc<=pc_out+STEP; ras_miss=1.
  7. otherwise: pc<=pc_out+STEP.
- Redirects override stall: a redirect while stall=1 still loads the target.
- pd_call and pd_ret both high: call wins; ret ignored, no pop.
- Arithmetic: pc_out+STEP is modulo 2^WIDTH and wraps silently, e.g. 0xFFFF_FFFC -> 0x0000_0000. Targets are used unmodified, with no alignment masking.
- RAS organisation: circular buffer, ptr in [0,RAS_DEPTH-1].
  - Push: write to entry ptr, then ptr=ptr+1 mod DEPTH.
  - Pop: ptr=ptr-1 mod DEPTH; read entry ptr-1.
  - Count saturates at RAS_DEPTH.
- RAS overflow: a push when full overwrites the oldest entry; count stays RAS_DEPTH. After DEPTH+1 calls and DEPTH+1 returns, the last return misses.
- Underflow: count never goes below 0. An empty pop performs no pointer move.
- ras_hit and ras_miss are cleared every cycle in which their condition does not occur, including stall and redirect cycles.

Test Plan:
1. Reset then 3 free-running cycles -> pc_out 0x3000, 0x3004, 0x3008, 0x300C; ras_count=0. Assert rst mid-cycle -> pc_out=0x3000 immediately, before the next clock edge.
2. Stall held 2 cycles at 0x3008, then br_valid with br_target=0x4000 while stall=1 -> pc_out stays 0x3008 for 2 cycles, then 0x4000.
3. At 0x3010 pd_call with pd_target=0x5000; at 0x5004 pd_ret -> pc_out 0x5000, 0x5004, 0x3014; ras_count 1 then 0; ras_hit pulses once.
4. RAS_DEPTH=4, 5 nested calls from 0x3000, 0x3100, 0x3200, 0x3300, 0x3400, then 5 returns -> returns yield 0x3404, 0x3304, 0x3204, 0x3104, then sequential with ras_miss=1; ras_count peaks at 4.
5. Same cycle: exc_valid (0x8000_0180), br_valid (0x6000), pd_call -> pc_out=0x8000_0180, ras_count=0. A subsequent pd_ret -> ras_miss=1.
6. pc_out=0xFFFF_FFFC with no events -> next pc_out=0x0000_0000. Simultaneous pd_call and pd_ret -> call target taken, count +1.
